// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch PC unit: FSM states, reset PC, tag and response layouts.
// No logic; pure declarations.
// No handshake of its own.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int unsigned MAX_OUTST_DEF = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } rsp_t;

endpackage

// File: rtl/fetch_pc_unit_fifo2.sv
// Two-entry synchronous FIFO with flush; head is visible combinationally.
// Latency: a push is readable at the head the cycle after it is written.
// No internal backpressure: callers must not push when full or pop when empty.
module fetch_pc_unit_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            cnt_q    <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign count    = cnt_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: issues in-order IMEM word fetches, buffers responses, delivers (pc, instr) to IF/ID.
// Latency: first request one cycle after reset release; out_valid the cycle after the matching response.
// Backpressure: requests stop once outstanding + buffered reaches 2; redirect blocks issue and delivery.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign_err
);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        epoch_q;
    logic        misalign_q;

    tag_t        tag_push_dat;
    tag_t        tag_head;
    logic        tag_push, tag_pop, tag_full, tag_empty;
    logic [1:0]  tag_cnt;

    rsp_t        buf_push_dat;
    rsp_t        buf_head;
    logic        buf_push, buf_pop, buf_full, buf_empty;
    logic [1:0]  buf_cnt;

    logic [2:0]  inflight;

    assign inflight       = {1'b0, tag_cnt} + {1'b0, buf_cnt};
    assign imem_req_valid = (state_q == S_RUN) && !redirect_valid && (inflight < 3'(MAX_OUTST));
    assign imem_req_addr  = pc_q;

    assign tag_push     = imem_req_valid && imem_req_ready;
    assign tag_push_dat = '{pc: pc_q, epoch: epoch_q};
    assign tag_pop      = imem_rsp_valid && !tag_empty;

    // Responses tagged with an older epoch belong to a squashed path and are discarded.
    assign buf_push     = tag_pop && (tag_head.epoch == epoch_q) && !redirect_valid;
    assign buf_push_dat = '{pc: tag_head.pc, instr: imem_rsp_data};

    assign out_valid    = !buf_empty && !redirect_valid;
    assign buf_pop      = out_valid && out_ready;
    assign out_pc       = buf_empty ? 32'h0 : buf_head.pc;
    assign out_instr    = buf_empty ? 32'h0 : buf_head.instr;
    assign misalign_err = misalign_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (tag_push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            epoch_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epoch_q    <= epoch_q ^ redirect_valid;
            misalign_q <= redirect_valid && (|redirect_pc[1:0]);
            case (state_q)
                S_BOOT:  state_q <= S_RUN;
                S_RUN:   if (halt)  state_q <= S_HALT;
                S_HALT:  if (!halt) state_q <= S_RUN;
                default: state_q <= S_BOOT;
            endcase
        end
    end

    // Tag FIFO is never flushed so stale responses still find their tag.
    fetch_pc_unit_fifo2 #(.W($bits(tag_t))) u_tag_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (1'b0),
        .push     (tag_push),
        .push_dat (tag_push_dat),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_cnt)
    );

    fetch_pc_unit_fifo2 #(.W($bits(rsp_t))) u_rsp_buf (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (redirect_valid),
        .push     (buf_push),
        .push_dat (buf_push_dat),
        .pop      (buf_pop),
        .head_dat (buf_head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_cnt)
    );

    a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rstn)
        imem_rsp_valid |-> !tag_empty);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(tag_push && tag_full && !tag_pop) && !(buf_push && buf_full && !buf_pop));
    a_max_outst: assert property (@(posedge clk) MAX_OUTST == 2);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: IMEM responder with request scoreboard, output scoreboard monitor.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    int out_cnt = 0;
    bit rsp_en = 1'b0;

    logic [31:0] exp_req [$];
    logic [63:0] exp_out [$];
    logic [31:0] pending [$];

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign_err   (misalign_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Instruction memory content: each word is the bitwise inverse of its address.
    task automatic push_out(input logic [31:0] pc);
        exp_out.push_back({pc, ~pc});
    endtask

    task automatic wait_req_to(input int target, input string name);
        int n = 0;
        while (req_cnt < target && n < 200) begin
            mid();
            n++;
        end
        chk(name, req_cnt, target);
    endtask

    task automatic wait_out_to(input int target, input string name);
        int n = 0;
        while (out_cnt < target && n < 200) begin
            mid();
            n++;
        end
        chk(name, out_cnt, target);
    endtask

    // IMEM: requests checked against the expected address list, answered one cycle later.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                req_cnt++;
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected: got addr %h expected none", imem_req_addr);
                end else begin
                    chk("req_addr", imem_req_addr, exp_req.pop_front());
                end
                pending.push_back(imem_req_addr);
            end
            @(posedge clk);
            #1;
            if (rsp_en && pending.size() > 0) begin
                a = pending.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~a;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_out.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got pc %h expected none", out_pc);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_pc", out_pc, e[63:32]);
                    chk("out_instr", out_instr, e[31:0]);
                end
            end
        end
    end

    initial begin
        #2 rstn = 1'b0;
        tick();
        tick();
        mid();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_misalign", misalign_err, 0);

        // Sequential fetch with a 1-cycle IMEM
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        rsp_en = 1'b1;
        exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
        push_out(32'h0); push_out(32'h4); push_out(32'h8);
        tick();
        rstn = 1'b1;
        mid();
        chk("boot_no_req", imem_req_valid, 0);
        wait_req_to(3, "seq_reqs");
        tick();
        imem_req_ready = 1'b0;
        wait_out_to(3, "seq_outs");

        // Output backpressure caps issue at two
        exp_req.push_back(32'hC); exp_req.push_back(32'h10); exp_req.push_back(32'h14);
        tick();
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (8) tick();
        mid();
        chk("bp_req_count", req_cnt, 5);
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_pc", out_pc, 32'hC);
        chk("bp_out_instr", out_instr, 32'hFFFF_FFF3);
        push_out(32'hC); push_out(32'h10); push_out(32'h14);
        tick();
        out_ready = 1'b1;
        wait_req_to(6, "bp_resume_req");
        tick();
        imem_req_ready = 1'b0;
        wait_out_to(6, "bp_outs");

        // Redirect to 0x200 with two requests outstanding
        mid();
        rsp_en = 1'b0;
        exp_req.push_back(32'h18); exp_req.push_back(32'h1C);
        tick();
        imem_req_ready = 1'b1;
        wait_req_to(8, "rd_outst_reqs");
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        mid();
        chk("rd_cycle_out_valid", out_valid, 0);
        chk("rd_cycle_req_valid", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        mid();
        exp_req.push_back(32'h200); exp_req.push_back(32'h204);
        push_out(32'h200); push_out(32'h204);
        rsp_en = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        wait_req_to(10, "rd_new_reqs");
        tick();
        imem_req_ready = 1'b0;
        wait_out_to(8, "rd_outs");

        // Misaligned redirect while two responses are buffered
        exp_req.push_back(32'h208); exp_req.push_back(32'h20C);
        tick();
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        wait_req_to(12, "mis_pre_reqs");
        tick();
        imem_req_ready = 1'b0;
        tick();
        tick();
        mid();
        chk("mis_pre_out_valid", out_valid, 1);
        chk("mis_pre_out_pc", out_pc, 32'h208);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        mid();
        chk("mis_cycle_out_valid", out_valid, 0);
        chk("mis_cycle_err", misalign_err, 0);
        tick();
        redirect_valid = 1'b0;
        mid();
        chk("mis_err_pulse", misalign_err, 1);
        chk("mis_flushed_valid", out_valid, 0);
        chk("mis_flushed_pc", out_pc, 32'h0);
        chk("mis_req_addr", imem_req_addr, 32'h100);
        exp_req.push_back(32'h100); exp_req.push_back(32'h104);
        push_out(32'h100); push_out(32'h104);
        tick();
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        mid();
        chk("mis_err_clear", misalign_err, 0);
        wait_req_to(14, "mis_reqs");
        tick();
        imem_req_ready = 1'b0;
        wait_out_to(10, "mis_outs");

        // Halt with responses still in flight
        mid();
        rsp_en = 1'b0;
        exp_req.push_back(32'h108); exp_req.push_back(32'h10C);
        tick();
        imem_req_ready = 1'b1;
        wait_req_to(15, "halt_req0");
        tick();
        halt = 1'b1;
        wait_req_to(16, "halt_req1");
        tick();
        mid();
        push_out(32'h108); push_out(32'h10C);
        rsp_en = 1'b1;
        chk("halt_no_req", imem_req_valid, 0);
        wait_out_to(12, "halt_outs");
        mid();
        chk("halt_idle_req_valid", imem_req_valid, 0);
        chk("halt_req_count", req_cnt, 16);
        tick();
        halt = 1'b0;
        exp_req.push_back(32'h110);
        push_out(32'h110);
        wait_req_to(17, "halt_resume_req");
        tick();
        imem_req_ready = 1'b0;
        wait_out_to(13, "halt_resume_out");

        // PC wrap at 2^32
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
        push_out(32'hFFFF_FFFC); push_out(32'h0);
        imem_req_ready = 1'b1;
        mid();
        chk("wrap_no_misalign", misalign_err, 0);
        wait_req_to(19, "wrap_reqs");
        tick();
        imem_req_ready = 1'b0;
        wait_out_to(15, "wrap_outs");
        mid();
        chk("wrap_next_addr", imem_req_addr, 32'h4);

        // Async reset with a request outstanding; its late response must vanish
        rsp_en = 1'b0;
        exp_req.push_back(32'h4);
        tick();
        imem_req_ready = 1'b1;
        wait_req_to(20, "ar_req");
        tick();
        imem_req_ready = 1'b0;
        mid();
        chk("ar_pre_req_valid", imem_req_valid, 1);
        chk("ar_pre_req_addr", imem_req_addr, 32'h8);
        #1 rstn = 1'b0;
        #1;
        chk("ar_req_valid", imem_req_valid, 0);
        chk("ar_req_addr", imem_req_addr, 32'h0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_pc", out_pc, 32'h0);
        chk("ar_out_instr", out_instr, 32'h0);
        chk("ar_misalign", misalign_err, 0);
        rsp_en = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        mid();
        chk("ar_late_rsp_out_valid", out_valid, 0);
        chk("ar_post_req_valid", imem_req_valid, 1);
        chk("ar_post_req_addr", imem_req_addr, 32'h0);
        chk("ar_out_count", out_cnt, 15);

        chk("left_exp_req", exp_req.size(), 0);
        chk("left_exp_out", exp_out.size(), 0);
        chk("left_pending", pending.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
